// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with post-reset hold and stall statistics
module pipe_ctrl #(
    parameter int STAGES      = 5,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 1023,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic [STAGES-1:0] stall_req,
    input  logic [STAGES-1:0] flush_req,
    input  logic              clr_stats,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] flush,
    output logic              hold_active,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              stall_timeout
);

    localparam int IDX_W  = $clog2(STAGES);
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    logic [HOLD_W-1:0] hold_cnt;
    logic              pend_valid;
    logic [IDX_W-1:0]  pend_idx;
    logic [CNT_W-1:0]  run_cnt;
    logic [CNT_W-1:0]  run_nxt;

    logic [STAGES-1:0] thermo;
    logic              blocked;
    logic              new_valid;
    logic [IDX_W-1:0]  new_idx;
    logic              cand_valid;
    logic [IDX_W-1:0]  cand_idx;
    logic              issue;
    logic              count_en;

    // Stage 0 has nothing younger to flush, so its request bit carries no meaning.
    logic flush_req0_unused;
    assign flush_req0_unused = flush_req[0];

    assign hold_active = (hold_cnt != '0);

    always_comb begin
        blocked = hold_active || !rdy;
        thermo  = '0;
        for (int j = 0; j < STAGES; j++) begin
            thermo[j] = |(stall_req >> j);
        end

        new_valid = 1'b0;
        new_idx   = '0;
        for (int i = 1; i < STAGES; i++) begin
            if (flush_req[i]) begin
                new_valid = 1'b1;
                new_idx   = IDX_W'(i);
            end
        end

        // The older of the new request and the pending one wins the single slot.
        cand_valid = new_valid || pend_valid;
        cand_idx   = (pend_valid && (!new_valid || pend_idx > new_idx)) ? pend_idx : new_idx;
        issue      = cand_valid && !blocked && !thermo[cand_idx];

        stall = blocked ? '1 : thermo;
        flush = '0;
        if (issue) begin
            for (int j = 0; j < STAGES; j++) begin
                if (IDX_W'(j) < cand_idx) begin
                    flush[j] = 1'b1;
                    stall[j] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_en = (stall != '0) && !hold_active;
        run_nxt  = run_cnt;
        if (count_en) begin
            if (run_cnt != TO_VAL) begin
                run_nxt = run_cnt + CNT_W'(1);
            end
        end else if (stall == '0) begin
            run_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= HOLD_W'(HOLD_CYCLES);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_idx   <= '0;
        end else if (issue) begin
            pend_valid <= 1'b0;
        end else if (cand_valid) begin
            pend_valid <= 1'b1;
            pend_idx   <= cand_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles  <= '0;
            run_cnt       <= '0;
            stall_timeout <= 1'b0;
        end else if (clr_stats) begin
            stall_cycles  <= '0;
            run_cnt       <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (count_en && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            run_cnt <= run_nxt;
            if (TIMEOUT != 0 && count_en && run_nxt == TO_VAL) begin
                stall_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

    localparam int S    = 5;
    localparam int HOLD = 2;
    localparam int TO   = 3;
    localparam int CW   = 8;

    logic          clk;
    logic          rst_n;
    logic          rdy;
    logic [S-1:0]  stall_req;
    logic [S-1:0]  flush_req;
    logic          clr_stats;
    logic [S-1:0]  stall;
    logic [S-1:0]  flush;
    logic          hold_active;
    logic [CW-1:0] stall_cycles;
    logic          stall_timeout;

    int tests = 0;
    int fails = 0;

    // Model state: pending flush, hold remaining, statistics.
    int m_hold_left;
    bit m_pv;
    int m_pi;
    int m_cnt;
    int m_run;
    bit m_to;
    // Model per-cycle results.
    int e_stall;
    int e_flush;
    bit e_hold;
    int e_k;
    bit e_issue;

    pipe_ctrl #(.STAGES(S), .HOLD_CYCLES(HOLD), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .stall_req(stall_req), .flush_req(flush_req),
        .clr_stats(clr_stats), .stall(stall), .flush(flush), .hold_active(hold_active),
        .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rdy       = 1'($urandom);
        stall_req = S'($urandom);
        flush_req = S'($urandom);
        clr_stats = 1'b0;
        m_pv = 0; m_pi = 0; m_cnt = 0; m_run = 0; m_to = 0; m_hold_left = HOLD;
        #1;
        chk("rst_hold", 32'(hold_active), 32'(HOLD > 0));
        chk("rst_stall", 32'(stall), 32'h1f);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_cnt", 32'(stall_cycles), 32'h0);
        chk("rst_to", 32'(stall_timeout), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_stall_held", 32'(stall), 32'h1f);
        chk("rst_cnt_held", 32'(stall_cycles), 32'h0);
        rst_n     = 1'b1;
        stall_req = '0;
        flush_req = '0;
        rdy       = 1'b1;
    endtask

    // Drive one cycle's inputs (at negedge), predict, and check outputs.
    task automatic step(input logic r, input logic [S-1:0] sr, input logic [S-1:0] fr, input logic c);
        int h;
        int k;
        int thermo;
        bit blocked;
        rdy = r; stall_req = sr; flush_req = fr; clr_stats = c;
        h = -1;
        for (int i = 0; i < S; i++) if (sr[i]) h = i;
        k = -1;
        for (int i = 1; i < S; i++) if (fr[i]) k = i;
        if (m_pv && m_pi > k) k = m_pi;
        e_hold  = (m_hold_left > 0);
        blocked = e_hold || !r;
        thermo  = blocked ? (1 << S) - 1 : (1 << (h + 1)) - 1;
        e_issue = (k >= 0) && !blocked && (h < k);
        e_flush = e_issue ? (1 << k) - 1 : 0;
        e_stall = e_issue ? (thermo & ~e_flush) : thermo;
        e_k     = k;
        #1;
        chk("stall", 32'(stall), 32'(e_stall));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("hold_active", 32'(hold_active), 32'(e_hold));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
        chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
    endtask

    // Advance across the rising edge and update the model.
    task automatic tick();
        bit en;
        @(posedge clk);
        if (e_issue) m_pv = 0;
        else if (e_k >= 0) begin m_pv = 1; m_pi = e_k; end
        en = (e_stall != 0) && !e_hold;
        if (clr_stats) begin
            m_cnt = 0; m_run = 0; m_to = 0;
        end else if (en) begin
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            if (m_run < TO) m_run++;
            if (TO != 0 && m_run == TO) m_to = 1;
        end else if (e_stall == 0) begin
            m_run = 0;
        end
        if (m_hold_left > 0) m_hold_left--;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; stall_req = '0; flush_req = '0; clr_stats = 1'b0;
        @(negedge clk);
        do_reset();

        // Post-reset hold
        step(1, 5'b00000, 5'b00000, 0); chk("d_hold1_stall", 32'(stall), 32'h1f); chk("d_hold1", 32'(hold_active), 1); tick();
        step(1, 5'b00000, 5'b00000, 0); chk("d_hold2_stall", 32'(stall), 32'h1f); chk("d_hold2", 32'(hold_active), 1); tick();
        step(1, 5'b00000, 5'b00000, 0); chk("d_run_stall", 32'(stall), 32'h00); chk("d_run_hold", 32'(hold_active), 0); tick();

        // Thermometer stall
        step(1, 5'b01010, 5'b00000, 0); chk("d_thermo_a", 32'(stall), 32'h0f); tick();
        step(1, 5'b00001, 5'b00000, 0); chk("d_thermo_b", 32'(stall), 32'h01); tick();

        // Immediate flush
        step(1, 5'b00000, 5'b00100, 0); chk("d_flush_now", 32'(flush), 32'h03); chk("d_flush_stall", 32'(stall), 32'h00); tick();
        step(1, 5'b00000, 5'b00000, 0); chk("d_flush_once", 32'(flush), 32'h00); tick();

        // Flush blocked by an older stall, issued when it drops
        step(1, 5'b01000, 5'b00100, 0); chk("d_pend_blk1", 32'(flush), 32'h00); tick();
        step(1, 5'b01000, 5'b00000, 0); chk("d_pend_blk2", 32'(flush), 32'h00); tick();
        step(1, 5'b01000, 5'b00000, 0); chk("d_pend_blk3", 32'(flush), 32'h00); tick();
        step(1, 5'b00000, 5'b00000, 0); chk("d_pend_issue", 32'(flush), 32'h03); tick();
        step(1, 5'b00000, 5'b00000, 0); chk("d_pend_gone", 32'(flush), 32'h00); tick();

        // Older request replaces the pending one
        step(1, 5'b10000, 5'b00100, 0); tick();
        step(1, 5'b10000, 5'b01000, 0); chk("d_repl_blk", 32'(flush), 32'h00); tick();
        step(1, 5'b00000, 5'b00000, 0); chk("d_repl_issue", 32'(flush), 32'h07); tick();
        step(1, 5'b00000, 5'b00000, 0); chk("d_repl_clear", 32'(flush), 32'h00); tick();

        // Timeout
        step(1, 5'b00000, 5'b00000, 1); tick();
        for (int i = 0; i < 4; i++) begin
            step(0, 5'b00000, 5'b00000, 0);
            chk("d_to_stall", 32'(stall), 32'h1f);
            chk("d_to_cnt", 32'(stall_cycles), 32'(i));
            chk("d_to_flag", 32'(stall_timeout), 32'(i >= 3));
            tick();
        end
        step(1, 5'b00000, 5'b00000, 0); chk("d_to_cnt4", 32'(stall_cycles), 4); chk("d_to_set", 32'(stall_timeout), 1); tick();
        step(1, 5'b00000, 5'b00000, 1); tick();
        step(1, 5'b00000, 5'b00000, 0); chk("d_clr_cnt", 32'(stall_cycles), 0); chk("d_clr_to", 32'(stall_timeout), 0); tick();

        // Reset with a flush pending discards it
        step(1, 5'b10000, 5'b00100, 0); tick();
        do_reset();
        step(1, 5'b00000, 5'b00000, 0); tick();
        step(1, 5'b00000, 5'b00000, 0); tick();
        step(1, 5'b00000, 5'b00000, 0); chk("d_rst_discard", 32'(flush), 32'h00); tick();

        // Counter saturation
        for (int i = 0; i < 260; i++) begin
            step(0, 5'b00000, 5'b00000, 0); tick();
        end
        step(1, 5'b00000, 5'b00000, 0); chk("d_sat", 32'(stall_cycles), 32'hff); tick();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            step(1'($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 2) == 0) ? S'($urandom) : '0,
                 ($urandom_range(0, 2) == 0) ? S'($urandom) : '0,
                 1'($urandom_range(0, 40) == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 5: number of pipeline stages (2..8); index 0 = IF, the youngest stage, and higher index = older stage.
REQ-002 Parameter HOLD_CYCLES, default 2: cycles for which all stages stall after reset release (0 = no hold).
REQ-003 Parameter TIMEOUT, default 1023: consecutive stall cycles that set stall_timeout (0 = disabled).
REQ-004 Parameter CNT_W, default 32: width of stall_cycles and of the run counter.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 rdy  input  1  global ready; 0 stalls every stage.
REQ-008 stall_req  input  STAGES  bit i: stage i requests a stall of stages 0..i.
REQ-009 flush_req  input  STAGES  bit k (k>=1): stage k requests a flush of stages 0..k-1; bit 0 is ignored.
REQ-010 clr_stats  input  1  synchronous clear of stall_cycles, run counter and stall_timeout.
REQ-011 stall  output  STAGES  bit j=1: stage j holds its state this cycle.
REQ-012 flush  output  STAGES  bit j=1: stage j loads a bubble this cycle.
REQ-013 hold_active  output  1  post-reset hold in progress.
REQ-014 stall_cycles  output  CNT_W  saturating count of stalled cycles.
REQ-015 stall_timeout  output  1  sticky flag: stall run reached TIMEOUT.

Function
REQ-016 After rst_n rises, a hold counter keeps hold_active=1 for exactly HOLD_CYCLES rising edges, then holds it at 0.
REQ-017 While hold_active=1 or rdy=0, stall SHALL be all ones and flush SHALL be all zeros.
REQ-018 Otherwise, stall is a thermometer code: with h = the highest set bit of stall_req, stall[j]=1 for j<=h and 0 above; with no request, stall=0.
REQ-019 stall and flush are combinational, taking effect in the same cycle as their inputs (zero latency).
REQ-020 Flush candidate k = the highest index among flush_req[STAGES-1:1] and the pending flush (if valid).
REQ-021 If a candidate exists, stall[k]=0, hold_active=0 and rdy=1, the flush is issued: flush[j]=1 and stall[j] forced to 0 for all j<k, for that cycle only.
REQ-022 If a candidate exists but cannot issue, it is stored as the pending flush (pend_valid, pend_idx) at the clock edge.
REQ-023 One pending slot only: a new request older than the pending one replaces it; a younger or equal-index one is absorbed (dropped).
REQ-024 The pending flush clears on the edge of the cycle in which it issues; a simultaneously arriving younger request is absorbed, not re-pended.
REQ-025 stall_cycles increments on each edge where stall!=0 and hold_active=0, saturates at all ones and does not wrap.
REQ-026 The run counter increments under the same condition, clears on any cycle with stall=0, and saturates at TIMEOUT.
REQ-027 stall_timeout sets on the edge where the run counter reaches TIMEOUT (TIMEOUT!=0) and stays set until clr_stats or reset.
REQ-028 clr_stats has priority over increment; the cycle in which it is asserted is not counted.

Reset
REQ-029 On rst_n=0, immediately and asynchronously: pend_valid=0, pend_idx=0, stall_cycles=0, run counter=0, stall_timeout=0, hold counter reloaded.
REQ-030 During reset, hold_active=1 if HOLD_CYCLES>0 (else 0), stall is all ones and flush is all zeros.
REQ-031 Reset asserted mid-stall or with a flush pending discards all state, and the hold restarts on release.

Verification (STAGES=5, HOLD_CYCLES=2)
REQ-032 Release rst_n with no requests -> stall=11111 and hold_active=1 for 2 cycles, then stall=00000.
REQ-033 stall_req=01010 -> stall=01111 in the same cycle; then stall_req=00001 -> stall=00001.
REQ-034 flush_req=00100 with no stall -> flush=00011 and stall=00000 for one cycle, then flush=00000.
REQ-035 stall_req=01000 held 3 cycles, flush_req=00100 pulsed in the first of them -> flush=00000 while stalled; the cycle stall_req drops -> flush=00011 once.
REQ-036 Pending k=2 while stall_req=10000, then flush_req=01000 pulsed -> pend_idx=3; when the stall drops -> flush=00111 once, and pend_valid=0 afterwards.
REQ-037 TIMEOUT=3, rdy=0 for 4 cycles -> stall=11111, stall_cycles=4, stall_timeout=1 from the 3rd edge; clr_stats pulse -> stall_cycles=0, stall_timeout=0.
